// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Reset sequencer for the 200 MHz domain behind the 25->200 MHz PLL.
//   Holds the downstream reset asserted until the (synchronised) PLL lock
//   flag has been continuously high for STABLE_CYCLES clocks. It re-asserts
//   the reset when lock drops for DEGLITCH consecutive synchronised cycles
//   while running. Sticky loss-of-lock status is kept for the host.
//
//   Optional feature (macro PLL_RESET_SEQ_TIMEOUT_EN): a sticky lock_timeout
//   flag. It sets once TIMEOUT_CYCLES clocks have been spent outside RUN
//   without reaching RUN.
//
// Ports
//   clock         in   PLL output clock (200 MHz)
//   resetn        in   asynchronous active-low reset
//   locked        in   PLL lock flag, asynchronous to clock
//   clear_sticky  in   single-cycle pulse, clears lock_lost / loss_count
//                      (and lock_timeout when present)
//   rst_out_n     out  registered active-low reset for the downstream domain
//   lock_lost     out  sticky: at least one lock loss since last clear
//   loss_count    out  8-bit saturating count of lock losses
//   lock_timeout  out  sticky timeout flag (only with PLL_RESET_SEQ_TIMEOUT_EN)

module pll_reset_seq #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int DEGLITCH       = 4,
  parameter int CNT_W          = 16
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       locked,
  input  logic       clear_sticky,
  output logic       rst_out_n,
  output logic       lock_lost,
  output logic [7:0] loss_count
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  , output logic     lock_timeout
`endif
);

  // Glitch counter only needs to reach DEGLITCH-1.
  localparam int G_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [G_W-1:0]   g_reg, g_next;
  logic             sync1_reg, lock_s_reg;
  logic             loss_event;
  logic             lock_lost_next;
  logic [7:0]       loss_count_next;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous lock flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_reg  <= 1'b0;
      lock_s_reg <= 1'b0;
    end else begin
      sync1_reg  <= locked;
      lock_s_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // State / counter registers. rst_out_n is taken from the next state, so it
  // is a plain flop output that rises on the very edge that enters RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= WAIT_LOCK;
      cnt_reg    <= '0;
      g_reg      <= '0;
      rst_out_n  <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      g_reg      <= g_next;
      rst_out_n  <= (state_next == RUN);
      lock_lost  <= lock_lost_next;
      loss_count <= loss_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    g_next     = '0;
    loss_event = 1'b0;

    case (state_reg)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s_reg) begin
          state_next = STABLE;
        end
      end

      STABLE: begin
        if (!lock_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RUN: begin
        // Any high sample restarts the deglitch window; only an unbroken
        // run of DEGLITCH low samples counts as a real loss of lock.
        if (lock_s_reg) begin
          g_next = '0;
        end else if (g_reg == G_W'(DEGLITCH - 1)) begin
          state_next = WAIT_LOCK;
          loss_event = 1'b1;
          g_next     = '0;
        end else begin
          g_next = g_reg + 1'b1;
        end
      end

      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky status. A loss event on the same edge as clear_sticky wins, so
  // the host never misses a loss that coincides with its clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    lock_lost_next  = lock_lost;
    loss_count_next = loss_count;
    if (loss_event) begin
      lock_lost_next = 1'b1;
      if (clear_sticky) begin
        loss_count_next = 8'd1;
      end else if (loss_count != 8'hFF) begin
        loss_count_next = loss_count + 8'd1;
      end
    end else if (clear_sticky) begin
      lock_lost_next  = 1'b0;
      loss_count_next = 8'd0;
    end
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Lock timeout. The counter advances on every cycle spent outside RUN and
  // parks at TIMEOUT_CYCLES, so the flag is set exactly once per attempt and
  // a clear_sticky while still unlocked does not immediately re-set it.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic             lock_timeout_next;

  always_comb begin
    tcnt_next         = tcnt_reg;
    lock_timeout_next = lock_timeout;

    if (state_next == RUN) begin
      tcnt_next = '0;
    end else if (tcnt_reg != CNT_W'(TIMEOUT_CYCLES)) begin
      tcnt_next = tcnt_reg + 1'b1;
    end

    if (state_reg != RUN && tcnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      lock_timeout_next = 1'b1;
    end else if (clear_sticky) begin
      lock_timeout_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcnt_reg     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      tcnt_reg     <= tcnt_next;
      lock_timeout <= lock_timeout_next;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Directed bench for pll_reset_seq with STABLE_CYCLES=16, DEGLITCH=4
//   (and TIMEOUT_CYCLES=100 when PLL_RESET_SEQ_TIMEOUT_EN is defined).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that same
//   point, so "after edge N" below means 1 ns after the N-th rising edge.
//   Expected release latency: 16+3 = 19 edges; loss latency: 4+2 = 6 edges.

`timescale 1ns/1ps

module tb_pll_reset_seq;

  localparam int STABLE_CYCLES = 16;
  localparam int DEGLITCH      = 4;
  localparam int REL_LAT       = STABLE_CYCLES + 3;  // 19
  localparam int LOSS_LAT      = DEGLITCH + 2;       // 6

  logic       clock;
  logic       resetn;
  logic       locked;
  logic       clear_sticky;
  logic       rst_out_n;
  logic       lock_lost;
  logic [7:0] loss_count;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  logic       lock_timeout;
`endif

  int checks = 0;
  int errors = 0;

  pll_reset_seq #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .DEGLITCH      (DEGLITCH),
    .CNT_W         (16)
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .locked       (locked),
    .clear_sticky (clear_sticky),
    .rst_out_n    (rst_out_n),
    .lock_lost    (lock_lost),
    .loss_count   (loss_count)
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    , .lock_timeout (lock_timeout)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance n rising edges, then move 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Apply reset mid-cycle, then release it 1 ns after a rising edge.
  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  // One RUN loss followed by relock back to RUN.
  task automatic lose_and_relock();
    locked = 1'b0;
    step(LOSS_LAT);
    locked = 1'b1;
    step(REL_LAT);
  endtask

  initial begin
    resetn       = 1'b0;
    locked       = 1'b1;
    clear_sticky = 1'b0;
    #1;

    // ---- reset state ----
    check("reset_rst_out_n", 32'(rst_out_n), 0);
    check("reset_lock_lost", 32'(lock_lost), 0);
    check("reset_loss_count", 32'(loss_count), 0);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    check("reset_lock_timeout", 32'(lock_timeout), 0);
`endif

    // ---- Test 1: locked held high through reset release ----
    step(2);
    resetn = 1'b1;
    step(REL_LAT - 1);
    check("t1_rst_edge18", 32'(rst_out_n), 0);
    step(1);
    check("t1_rst_edge19", 32'(rst_out_n), 1);
    check("t1_lock_lost", 32'(lock_lost), 0);
    check("t1_loss_count", 32'(loss_count), 0);

    // ---- Test 2: 2-cycle lock dropout while in STABLE ----
    do_reset();
    step(13);                 // cnt is 10 after edge 13
    locked = 1'b0;
    step(2);
    locked = 1'b1;            // first high sample at next edge
    step(REL_LAT - 1);
    check("t2_rst_before", 32'(rst_out_n), 0);
    step(1);
    check("t2_rst_release", 32'(rst_out_n), 1);
    check("t2_lock_lost", 32'(lock_lost), 0);
    check("t2_loss_count", 32'(loss_count), 0);

    // ---- Test 3: short glitch ignored, long drop counted ----
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t3_glitch_rst", 32'(rst_out_n), 1);
      step(1);
    end
    check("t3_glitch_lost", 32'(lock_lost), 0);

    locked = 1'b0;
    step(LOSS_LAT - 1);
    check("t3_rst_edge5", 32'(rst_out_n), 1);
    step(1);
    check("t3_rst_edge6", 32'(rst_out_n), 0);
    check("t3_lock_lost", 32'(lock_lost), 1);
    check("t3_loss_count", 32'(loss_count), 1);
    locked = 1'b1;
    step(REL_LAT - 1);
    check("t3_relock_before", 32'(rst_out_n), 0);
    step(1);
    check("t3_relock_rst", 32'(rst_out_n), 1);

    // ---- Test 4: saturation, clear, clear-vs-loss collision ----
    for (int i = 0; i < 253; i++) lose_and_relock();
    check("t4_count_254", 32'(loss_count), 254);
    lose_and_relock();
    check("t4_count_255", 32'(loss_count), 255);
    lose_and_relock();
    lose_and_relock();
    check("t4_count_sat", 32'(loss_count), 255);
    check("t4_lock_lost", 32'(lock_lost), 1);

    clear_sticky = 1'b1;
    step(1);
    clear_sticky = 1'b0;
    check("t4_clr_lost", 32'(lock_lost), 0);
    check("t4_clr_count", 32'(loss_count), 0);
    check("t4_clr_rst", 32'(rst_out_n), 1);

    locked = 1'b0;
    step(LOSS_LAT - 1);
    clear_sticky = 1'b1;      // coincides with the loss edge
    step(1);
    clear_sticky = 1'b0;
    check("t4_coll_lost", 32'(lock_lost), 1);
    check("t4_coll_count", 32'(loss_count), 1);
    check("t4_coll_rst", 32'(rst_out_n), 0);
    locked = 1'b1;
    step(REL_LAT);
    check("t4_relock_rst", 32'(rst_out_n), 1);

    // ---- Test 5: asynchronous reset mid-RUN ----
    #2;
    resetn = 1'b0;
    #1;
    check("t5_async_rst", 32'(rst_out_n), 0);
    check("t5_async_lost", 32'(lock_lost), 0);
    check("t5_async_count", 32'(loss_count), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step(REL_LAT - 1);
    check("t5_restart_before", 32'(rst_out_n), 0);
    step(1);
    check("t5_restart_rst", 32'(rst_out_n), 1);

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    // ---- Test 6: lock timeout ----
    check("t6_run_timeout", 32'(lock_timeout), 0);
    locked = 1'b0;
    do_reset();
    step(99);
    check("t6_edge99", 32'(lock_timeout), 0);
    step(1);
    check("t6_edge100", 32'(lock_timeout), 1);
    step(20);
    check("t6_held", 32'(lock_timeout), 1);
    check("t6_rst", 32'(rst_out_n), 0);
    clear_sticky = 1'b1;
    step(1);
    clear_sticky = 1'b0;
    check("t6_cleared", 32'(lock_timeout), 0);
    step(5);
    check("t6_stays_clear", 32'(lock_timeout), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
